// File: rtl/dmix_i2s_clkgen_if.sv
// dmix_i2s_clkgen_if: rate handshake and frame timing signals of the I2S clock generator.
interface dmix_i2s_clkgen_if;
    logic [1:0] rate_i;
    logic       rate_req_i;
    logic       rate_ack_o;
    logic [1:0] rate_o;
    logic       bck_o;
    logic       lrck_o;
    logic       bit_strobe_o;
    logic       frame_start_o;
    logic [5:0] bit_index_o;
    logic       ready_o;
    modport master (
        output rate_i, rate_req_i,
        input  rate_ack_o, rate_o, bck_o, lrck_o, bit_strobe_o, frame_start_o, bit_index_o, ready_o
    );
    modport slave (
        input  rate_i, rate_req_i,
        output rate_ack_o, rate_o, bck_o, lrck_o, bit_strobe_o, frame_start_o, bit_index_o, ready_o
    );
endinterface

// File: rtl/dmix_i2s_clkgen.sv
// dmix_i2s_clkgen: 64-bit stereo I2S frame timing at 48/96/192 kHz from 98.304 MHz.
// Optional settle muting after reset/rate change with `define DMIX_CLKGEN_SETTLE_EN.
module dmix_i2s_clkgen #(
    parameter int SETTLE_FRAMES = 4
) (
    input logic         clk983040,
    input logic         rst_n,
    dmix_i2s_clkgen_if.slave bus
);
    logic [4:0] div_cnt, div_nxt, per_m1, half_nxt;
    logic [5:0] bit_cnt, bit_nxt;
    logic [1:0] rate, rate_nxt, pend_rate, pend_rate_nxt;
    logic       pend_vld, pend_vld_nxt, wrap, div_wrap, req_ok, ack_nxt, ready, ready_nxt;
    always_comb begin
        per_m1        = 5'd31 >> rate;
        div_wrap      = div_cnt == per_m1;
        wrap          = div_wrap && bit_cnt == 6'd63;
        div_nxt       = div_wrap ? 5'd0 : div_cnt + 5'd1;
        bit_nxt       = div_wrap ? bit_cnt + 6'd1 : bit_cnt;
        ack_nxt       = wrap && pend_vld;
        rate_nxt      = ack_nxt ? pend_rate : rate;
        half_nxt      = 5'd16 >> rate_nxt;
        // a request in the wrap cycle survives as pending for the following wrap
        req_ok        = bus.rate_req_i && bus.rate_i != 2'b11;
        pend_vld_nxt  = req_ok || (pend_vld && !wrap);
        pend_rate_nxt = req_ok ? bus.rate_i : pend_rate;
    end
`ifdef DMIX_CLKGEN_SETTLE_EN
    logic [3:0] settle_cnt, settle_nxt;
    always_comb begin
        settle_nxt = settle_cnt;
        ready_nxt  = ready;
        if (wrap) begin
            ready_nxt  = !ack_nxt && settle_cnt >= 4'(SETTLE_FRAMES);
            settle_nxt = ack_nxt ? 4'd1 : (settle_cnt == 4'd15 ? 4'd15 : settle_cnt + 4'd1);
        end
    end
    always_ff @(posedge clk983040)
        settle_cnt <= !rst_n ? 4'd0 : settle_nxt;
`else
    logic unused_settle;
    assign unused_settle = SETTLE_FRAMES[0];
    assign ready_nxt     = ready || wrap;
`endif
    always_ff @(posedge clk983040) begin
        if (!rst_n) begin
            div_cnt            <= 5'd31;
            bit_cnt            <= 6'd63;
            rate               <= 2'b00;
            pend_vld           <= 1'b0;
            pend_rate          <= 2'b00;
            ready              <= 1'b0;
            bus.bck_o          <= 1'b1;
            bus.lrck_o         <= 1'b0;
            bus.bit_strobe_o   <= 1'b0;
            bus.frame_start_o  <= 1'b0;
            bus.rate_ack_o     <= 1'b0;
            bus.rate_o         <= 2'b00;
            bus.bit_index_o    <= 6'd63;
        end else begin
            div_cnt            <= div_nxt;
            bit_cnt            <= bit_nxt;
            rate               <= rate_nxt;
            pend_vld           <= pend_vld_nxt;
            pend_rate          <= pend_rate_nxt;
            ready              <= ready_nxt;
            bus.bck_o          <= div_nxt >= half_nxt;
            bus.lrck_o         <= bit_nxt[5];
            bus.bit_strobe_o   <= div_nxt == half_nxt;
            bus.frame_start_o  <= bit_nxt == 6'd0 && div_nxt == 5'd0;
            bus.rate_ack_o     <= ack_nxt;
            bus.rate_o         <= rate_nxt;
            bus.bit_index_o    <= bit_nxt;
        end
    end
    assign bus.ready_o = ready;
endmodule

// File: tb/tb_dmix_i2s_clkgen.sv
// tb_dmix_i2s_clkgen: randomized scoreboard bench against a frame-position reference model.
module tb_dmix_i2s_clkgen;
    localparam int SETTLE = 4;
    logic clk983040 = 1'b0;
    logic rst_n;
    dmix_i2s_clkgen_if bus ();
    dmix_i2s_clkgen #(.SETTLE_FRAMES(SETTLE)) dut (.clk983040(clk983040), .rst_n(rst_n), .bus(bus));
    always #5 clk983040 = ~clk983040;

    typedef struct {
        int          cyc;
        logic [13:0] v;
    } exp_t;
    exp_t q[$];
    int vectors = 0, miscompares = 0, cyc = 0;

    int m_t = 2047, m_rate = 0, m_pend_v = 0, m_pend_r = 0, m_fidx = -1;
    bit m_ready = 0;

    task automatic model_edge(input logic r, input logic req, input logic [1:0] rt);
        int p, b, d;
        bit ack;
        exp_t e;
        ack = 0;
        if (!r) begin
            m_t = 2047; m_rate = 0; m_pend_v = 0; m_fidx = -1; m_ready = 0;
            e.v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd63, 2'd0};
        end else begin
            p = 32 >> m_rate;
            if (m_t == 64 * p - 1) begin
                m_t = 0;
                ack = m_pend_v != 0;
                if (ack) m_rate = m_pend_r;
                m_pend_v = 0;
`ifdef DMIX_CLKGEN_SETTLE_EN
                m_fidx = ack ? 0 : m_fidx + 1;
                m_ready = m_fidx >= SETTLE;
`else
                m_ready = 1;
`endif
            end else m_t++;
            if (req && rt != 2'b11) begin m_pend_v = 1; m_pend_r = rt; end
            p = 32 >> m_rate;
            b = m_t / p;
            d = m_t % p;
            e.v = {d >= p / 2, b >= 32, d == p / 2, m_t == 0, ack, m_ready, 6'(b), 2'(m_rate)};
        end
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic step(input logic r, input logic req, input logic [1:0] rt);
        rst_n = r;
        bus.rate_req_i = req;
        bus.rate_i = rt;
        @(posedge clk983040);
        #1;
        cyc++;
        model_edge(r, req, rt);
        bus.rate_req_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'($urandom_range(0, 3)));
    endtask

    always @(negedge clk983040) begin
        exp_t e;
        logic [13:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {bus.bck_o, bus.lrck_o, bus.bit_strobe_o, bus.frame_start_o, bus.rate_ack_o,
                   bus.ready_o, bus.bit_index_o, bus.rate_o};
            vectors++;
            if (act !== e.v) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL outputs cycle %0d {bck,lrck,strb,fs,ack,rdy,idx,rate}: got %b want %b",
                             e.cyc, act, e.v);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.rate_req_i = 1'b0;
        bus.rate_i = 2'b00;
        repeat (3) step(1'b0, 1'b0, 2'b00);
        idle(2300);
        step(1'b1, 1'b1, 2'b10);
        idle(1500);
        idle(100);
        step(1'b1, 1'b1, 2'b01);
        idle(100);
        step(1'b1, 1'b1, 2'b10);
        idle(700);
        step(1'b1, 1'b1, 2'b11);
        idle(1700);
        step(1'b1, 1'b1, 2'b10);
        idle(600);
        while (m_t != 64 * (32 >> m_rate) - 1) idle(1);
        step(1'b1, 1'b1, 2'b00);
        idle(2600);
        step(1'b1, 1'b1, 2'b00);
        idle(2200);
        step(1'b1, 1'b1, 2'b01);
        idle(2500);
        step(1'b1, 1'b1, 2'b10);
        step(1'b0, 1'b0, 2'b00);
        idle(4400);
        for (int i = 0; i < 30000; i++)
            step($urandom_range(0, 7999) != 0, $urandom_range(0, 399) == 0, 2'($urandom_range(0, 3)));
        repeat (3) @(negedge clk983040);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmix_i2s_clkgen.md
# dmix_i2s_clkgen

Serial audio frame timing generator for the mixer's 98.304 MHz domain, directly downstream of the clock manager that produces clk983040. Derives the bit clock, LR clock, per-bit sample strobe and frame-start strobe for 64-bit stereo frames at 48, 96 or 192 kHz. Rate changes are requested by a pulse handshake and take effect only on a frame boundary. Serializers and deserializers in the same domain consume its outputs.

## Interface
Parameters:
- SETTLE_FRAMES, 4: muted frames after reset or an applied rate change; range 1..15; used only with DMIX_CLKGEN_SETTLE_EN.

Ports:
- clk983040  in  1  98.304 MHz clock; sole clock of the block.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- rate_i  in  2  requested rate: 00 = 48 kHz, 01 = 96 kHz, 10 = 192 kHz, 11 = reserved.
- rate_req_i  in  1  one-cycle pulse; rate_i is sampled in the same cycle.
- rate_ack_o  out  1  one-cycle pulse when the requested rate takes effect.
- rate_o  out  2  rate currently in effect.
- bck_o  out  1  bit clock.
- lrck_o  out  1  0 = left half (bits 0..31), 1 = right half (bits 32..63).
- bit_strobe_o  out  1  one-cycle pulse on the first bck_o-high cycle of each bit.
- frame_start_o  out  1  one-cycle pulse on the first cycle of bit 0.
- bit_index_o  out  6  current bit number, 0..63.
- ready_o  out  1  high when frames are valid for audio.

## Operation
- Period P = 32 >> rate clocks per bit: 32, 16 or 8. Each frame is 64 bits: 2048, 1024 or 512 clocks.
- Counters:
  - div_cnt (5b) counts 0..P-1.
  - bit_cnt (6b) increments when div_cnt wraps and itself wraps 63 -> 0.
- All outputs are flops loaded from next-state decode, so each output reflects the counter values of the same cycle:
  - bck_o = (div_cnt >= P/2).
  - lrck_o = bit_cnt[5].
  - bit_strobe_o = (div_cnt == P/2).
  - frame_start_o = (bit_cnt == 0 && div_cnt == 0).
  - bit_index_o = bit_cnt.
- Rate request:
  - rate_req_i with rate_i != 11 latches rate_i into a pending register.
  - rate_req_i with rate_i == 11 is ignored: no pending state, no ack.
  - The pending rate is applied at the next frame wrap, i.e. on the edge leaving bit_cnt = 63, div_cnt = P_old-1.
  - The first frame at the new rate begins with frame_start_o and rate_ack_o asserted together, and rate_o updated in the same cycle.
- Request boundary cases:
  - A second request while one is pending overwrites the pending value; exactly one ack is issued.
  - A request for the rate already in effect is still acked at the next frame boundary.
  - A request arriving in the same cycle as a frame wrap is applied at the following wrap, not this one.
  - The period never changes mid-frame.

## Timing
- Values during reset (rst_n low at an edge):
  - div_cnt = 31, bit_cnt = 63, rate_o = 00.
  - Pending request cleared.
  - bck_o = 1; lrck_o, bit_strobe_o, frame_start_o, rate_ack_o and ready_o are all 0; bit_index_o = 63.
- First edge with rst_n high: counters wrap to 0/0, so frame_start_o = 1 in the first cycle after reset release, followed by the 48 kHz pattern.
- Reset asserted mid-frame or with a request pending takes effect on the next edge: the pending request is dropped and no ack is issued.
- Output latency from counter state is 0 cycles (registered decode). rate_ack_o has a fixed relationship to frame_start_o: the two are coincident.

## Configuration
- DMIX_CLKGEN_SETTLE_EN defined:
  - ready_o drops in the cycle frame timing starts after reset, and again in the rate_ack_o cycle.
  - It rises together with frame_start_o of the (SETTLE_FRAMES+1)-th frame at the current rate.
  - A 4-bit frame counter implements this.
- Not defined:
  - ready_o rises with the first frame_start_o after reset and remains high through rate changes.
  - No settle counter is synthesized.

## Test plan
- Reset release at 48 kHz:
  - frame_start_o in cycle 1.
  - bck_o period 32 cycles with 16 high.
  - lrck_o rises on cycle 1024 of the frame.
  - Next frame_start_o at cycle 2049.
- rate_req_i with rate_i = 10 mid-frame at 48 kHz:
  - No change until the frame wrap.
  - Then rate_ack_o and frame_start_o pulse together, rate_o = 10, bck_o period 8, frame length 512.
- Two requests (01, then 10) within one frame: a single ack, rate_o = 10.
- rate_req_i with rate_i = 11: no ack, and rate_o and timing are unchanged across 3 frames.
- Assert rst_n low for 1 cycle mid-frame at 96 kHz with a request pending:
  - The reset values listed under Timing appear.
  - Timing restarts at 48 kHz and no ack is issued.
- With DMIX_CLKGEN_SETTLE_EN, SETTLE_FRAMES = 4:
  - ready_o is low for frames 0..3 and rises with frame 4's frame_start_o.
  - After a rate change it is low for 4 frames at the new rate.
  - Without the macro, ready_o is high from frame 0.
